// File: rtl/tilelink_a_request_queue_if.sv
// TileLink A-channel request queue bus bundle.
// A in (upstream), A out (downstream), and the observed D handshake.
interface tilelink_a_request_queue_if;
  logic        in_a_valid;
  logic        in_a_ready;
  logic [79:0] in_a_bits;
  logic        out_a_valid;
  logic        out_a_ready;
  logic [79:0] out_a_bits;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_bits_opcode;
  logic [3:0]  d_bits_size;

  modport slave (
    input  in_a_valid,
    input  in_a_bits,
    output in_a_ready,
    output out_a_valid,
    output out_a_bits,
    input  out_a_ready,
    input  d_valid,
    input  d_ready,
    input  d_bits_opcode,
    input  d_bits_size
  );

  modport master (
    output in_a_valid,
    output in_a_bits,
    input  in_a_ready,
    input  out_a_valid,
    input  out_a_bits,
    output out_a_ready,
    output d_valid,
    output d_ready,
    output d_bits_opcode,
    output d_bits_size
  );
endinterface

// File: rtl/tilelink_a_request_queue.sv
// TileLink A request FIFO with an outstanding-message cap fed by D snooping.
// Ports: clock, resetn (async low), bus (A in/out, D snoop), occupancy, inflight, proto_err.
module tilelink_a_request_queue #(
  parameter int DEPTH        = 4,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                      clock,
  input  logic                      resetn,
  tilelink_a_request_queue_if.slave bus,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic [3:0]                inflight,
  output logic                      proto_err
);

  localparam int AW = $clog2(DEPTH);

  logic [79:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        resetn_q;
  logic [15:0] a_beat;
  logic [15:0] d_beat;
  logic        stall_q;
  logic [79:0] bits_q;

  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic [2:0]  h_op;
  logic [3:0]  h_size;
  logic [15:0] a_cnt;
  logic [15:0] d_cnt;
  logic        a_first;
  logic        a_last;
  logic        d_fire;
  logic        d_last;
  logic        inc;
  logic        dec_req;
  logic        underflow;
  logic        dec;
  logic        drop_err;
  logic        chg_err;

  function automatic logic [15:0] beats(input logic [3:0] size);
    if (size <= 4'd2) return 16'd1;
    return 16'd1 << (size - 4'd2);
  endfunction

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign bus.in_a_ready = resetn_q && !full;
  assign push = bus.in_a_valid && bus.in_a_ready;

  assign bus.out_a_bits = mem[rd_ptr[AW-1:0]];
  assign h_op   = bus.out_a_bits[78:76];
  assign h_size = bus.out_a_bits[72:69];

  // Put/Arith/Logic carry data beats; everything else is one beat.
  assign a_cnt   = (h_op <= 3'd3) ? beats(h_size) : 16'd1;
  assign a_first = (a_beat == 16'd0);
  assign a_last  = (a_beat == a_cnt - 16'd1);

  // Only a new message is held back by the cap.
  assign bus.out_a_valid = !empty &&
    !(a_first && inflight == 4'(MAX_INFLIGHT));
  assign pop = bus.out_a_valid && bus.out_a_ready;

  assign d_cnt  = (bus.d_bits_opcode == 3'd1) ?
                  beats(bus.d_bits_size) : 16'd1;
  assign d_fire = bus.d_valid && bus.d_ready;
  assign d_last = (d_beat == d_cnt - 16'd1);

  assign inc       = pop && a_first;
  assign dec_req   = d_fire && d_last;
  assign underflow = dec_req && (inflight == 4'd0);
  assign dec       = dec_req && !underflow;

  assign drop_err = stall_q && !bus.out_a_valid;
  assign chg_err  = stall_q && (bus.out_a_bits != bits_q);

  assign occupancy = wr_ptr - rd_ptr;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.in_a_bits;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      resetn_q  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      a_beat    <= '0;
      d_beat    <= '0;
      inflight  <= '0;
      proto_err <= 1'b0;
      stall_q   <= 1'b0;
      bits_q    <= '0;
    end else begin
      resetn_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        a_beat <= a_last ? 16'd0 : a_beat + 16'd1;
      end
      if (d_fire) d_beat <= d_last ? 16'd0 : d_beat + 16'd1;
      if (inc && !dec) inflight <= inflight + 4'd1;
      else if (dec && !inc) inflight <= inflight - 4'd1;
      if (underflow || drop_err || chg_err) proto_err <= 1'b1;
      stall_q <= bus.out_a_valid && !bus.out_a_ready;
      bits_q  <= bus.out_a_bits;
    end
  end

endmodule

// File: tb/tb_tilelink_a_request_queue.sv
// Scoreboard bench for tilelink_a_request_queue.
// Directed A/D scenarios; a negedge monitor checks every A beat fired.
module tb_tilelink_a_request_queue;

  logic clock;
  logic resetn;
  logic [2:0] occupancy;
  logic [3:0] inflight;
  logic proto_err;

  int errors = 0;
  int checks = 0;
  logic [79:0] exp_q [$];

  tilelink_a_request_queue_if bus();

  tilelink_a_request_queue #(
    .DEPTH(4),
    .MAX_INFLIGHT(2)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .bus(bus),
    .occupancy(occupancy),
    .inflight(inflight),
    .proto_err(proto_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic logic [79:0] mk(input logic [2:0] op,
      input logic [3:0] sz, input logic [31:0] addr,
      input logic [31:0] data);
    return {1'b0, op, 3'b000, sz, 1'b0, addr, 4'hf, data};
  endfunction

  task automatic send(input logic [79:0] b);
    bit done;
    done = 0;
    bus.in_a_valid = 1'b1;
    bus.in_a_bits  = b;
    for (int i = 0; i < 50 && !done; i++) begin
      if (bus.in_a_ready) begin
        done = 1;
        exp_q.push_back(b);
      end
      step(1);
    end
    bus.in_a_valid = 1'b0;
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL send_timeout got=0 want=1");
    end
  endtask

  task automatic d_ack(input logic [2:0] op, input logic [3:0] sz);
    bus.d_valid       = 1'b1;
    bus.d_ready       = 1'b1;
    bus.d_bits_opcode = op;
    bus.d_bits_size   = sz;
    step(1);
    bus.d_valid = 1'b0;
  endtask

  always @(negedge clock) begin
    if (resetn && bus.out_a_valid && bus.out_a_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected got=%0h want=none",
                 bus.out_a_bits);
      end else begin
        if (bus.out_a_bits !== exp_q[0]) begin
          errors++;
          $display("FAIL a_beat got=%0h want=%0h",
                   bus.out_a_bits, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    resetn            = 1'b0;
    bus.in_a_valid    = 1'b0;
    bus.in_a_bits     = '0;
    bus.out_a_ready   = 1'b0;
    bus.d_valid       = 1'b0;
    bus.d_ready       = 1'b0;
    bus.d_bits_opcode = '0;
    bus.d_bits_size   = '0;
    step(2);
    chk("rst_in_ready", 32'(bus.in_a_ready), 0);
    chk("rst_out_valid", 32'(bus.out_a_valid), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_inflight", 32'(inflight), 0);
    chk("rst_err", 32'(proto_err), 0);
    resetn = 1'b1;
    #1;
    chk("sync_ready_lo", 32'(bus.in_a_ready), 0);
    step(1);
    chk("sync_ready_hi", 32'(bus.in_a_ready), 1);

    // T1 single Get, AccessAckData completes it
    bus.out_a_ready = 1'b1;
    send(mk(3'd4, 4'd2, 32'h1000, 32'h0));
    chk("t1_valid", 32'(bus.out_a_valid), 1);
    chk("t1_occ", 32'(occupancy), 1);
    step(1);
    chk("t1_inflight1", 32'(inflight), 1);
    chk("t1_occ0", 32'(occupancy), 0);
    d_ack(3'd1, 4'd2);
    chk("t1_inflight0", 32'(inflight), 0);

    // T2 four-beat PutFull held then released
    bus.out_a_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(mk(3'd0, 4'd4, 32'h2000, 32'hA0 + 32'(i)));
    chk("t2_occ4", 32'(occupancy), 4);
    chk("t2_full", 32'(bus.in_a_ready), 0);
    chk("t2_valid", 32'(bus.out_a_valid), 1);
    bus.out_a_ready = 1'b1;
    step(4);
    chk("t2_occ0", 32'(occupancy), 0);
    chk("t2_inflight", 32'(inflight), 1);
    d_ack(3'd0, 4'd4);
    chk("t2_inflight0", 32'(inflight), 0);

    // T3 cap at two outstanding Gets
    send(mk(3'd4, 4'd2, 32'h3000, 32'h0));
    send(mk(3'd4, 4'd2, 32'h3004, 32'h0));
    send(mk(3'd4, 4'd2, 32'h3008, 32'h0));
    step(2);
    chk("t3_inflight2", 32'(inflight), 2);
    chk("t3_occ1", 32'(occupancy), 1);
    chk("t3_held", 32'(bus.out_a_valid), 0);
    d_ack(3'd1, 4'd2);
    chk("t3_inflight1", 32'(inflight), 1);
    chk("t3_release", 32'(bus.out_a_valid), 1);
    step(1);
    chk("t3_inflight2b", 32'(inflight), 2);
    d_ack(3'd1, 4'd2);
    d_ack(3'd1, 4'd2);
    chk("t3_drain", 32'(inflight), 0);

    // T4 simultaneous issue and completion
    send(mk(3'd4, 4'd2, 32'h4000, 32'h0));
    step(1);
    chk("t4_inflight1", 32'(inflight), 1);
    bus.out_a_ready = 1'b0;
    send(mk(3'd4, 4'd2, 32'h4004, 32'h0));
    bus.out_a_ready   = 1'b1;
    bus.d_valid       = 1'b1;
    bus.d_ready       = 1'b1;
    bus.d_bits_opcode = 3'd1;
    bus.d_bits_size   = 4'd2;
    step(1);
    bus.d_valid = 1'b0;
    chk("t4_inflight_same", 32'(inflight), 1);
    chk("t4_occ0", 32'(occupancy), 0);
    chk("t4_no_err", 32'(proto_err), 0);
    d_ack(3'd1, 4'd2);
    chk("t4_inflight0", 32'(inflight), 0);

    // T5 spurious D completion
    d_ack(3'd0, 4'd0);
    chk("t5_err", 32'(proto_err), 1);
    chk("t5_inflight", 32'(inflight), 0);
    step(2);
    chk("t5_err_hold", 32'(proto_err), 1);

    // T6 reset in the middle of a burst
    bus.out_a_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(mk(3'd0, 4'd4, 32'h6000, 32'hC0 + 32'(i)));
    bus.out_a_ready = 1'b1;
    step(2);
    chk("t6_occ2", 32'(occupancy), 2);
    resetn = 1'b0;
    #1;
    exp_q.delete();
    chk("t6_occ0", 32'(occupancy), 0);
    chk("t6_inflight0", 32'(inflight), 0);
    chk("t6_valid0", 32'(bus.out_a_valid), 0);
    chk("t6_err0", 32'(proto_err), 0);
    step(1);
    resetn = 1'b1;
    step(2);
    send(mk(3'd4, 4'd2, 32'h7000, 32'h0));
    step(1);
    chk("t6_first_beat", 32'(inflight), 1);
    chk("t6_occ_after", 32'(occupancy), 0);
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
